pwm_ramp_ctrl: RTL

//  Configuration sequencer for the PWM generator. Accepts period/duty requests (µs) over a

---
 rtl/pwm_pkg.sv | 31 +++
 rtl/pwm_frame_timer.sv | 30 +++
 rtl/pwm_ramp_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: types and helpers shared by the PWM config sequencer and generator.
// The time conversion mirrors the generator, including its width truncation.
package pwm_pkg;

   typedef enum logic [1:0] {IDLE, RUN, RAMP, STOP} pwm_state_t;

   localparam int unsigned NS_PER_US = 1000;

   function automatic logic [63:0] us_to_cycles(
      input logic [63:0] value,
      input int unsigned clk_period,
      input int unsigned dw
   );
      logic [63:0] ns;
      ns = value * 64'(NS_PER_US);
      if (dw < 64) ns = ns & ((64'd1 << dw) - 64'd1);
      return ns / 64'(clk_period);
   endfunction

   function automatic logic cfg_valid_chk(
      input logic [63:0] period,
      input logic [63:0] duty,
      input int unsigned dw
   );
      logic [63:0] ns;
      ns = period * 64'(NS_PER_US);
      return (period != 64'd0) && (duty <= period) &&
             ((dw >= 64) || ((ns >> dw) == 64'd0));
   endfunction

endpackage

// File: rtl/pwm_frame_timer.sv
// pwm_frame_timer: frame counter that tracks the PWM generator cycle for cycle.
// boundary is the last cycle of a frame; with a zero period every cycle is one.
module pwm_frame_timer #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] period_cycles,
   output logic                  boundary,
   output logic                  frame_start
);

   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] frame_cnt;

   assign boundary    = !(frame_cnt < period_cycles);
   assign frame_start = boundary;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt <= ONE;
      end else if (boundary) begin
         frame_cnt <= ONE;
      end else begin
         frame_cnt <= frame_cnt + ONE;
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: validates period/duty requests and hands them to the PWM
// generator only at frame boundaries, optionally ramping duty per frame.
import pwm_pkg::*;

module pwm_ramp_ctrl #(
   parameter int CLK_PERIOD = 100,
   parameter int DATA_WIDTH = 32,
   parameter int STEP_US    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  cfg_valid,
   output logic                  cfg_ready,
   input  logic [DATA_WIDTH-1:0] cfg_period_us,
   input  logic [DATA_WIDTH-1:0] cfg_duty_us,
   input  logic                  cfg_ramp_en,
   output logic                  cfg_err,
   output logic [DATA_WIDTH-1:0] pwm_period_us,
   output logic [DATA_WIDTH-1:0] pwm_duty_us,
   output logic                  frame_start,
   output logic                  busy
);

   localparam int DW = DATA_WIDTH;
   localparam logic [DW-1:0] STEP = DW'(STEP_US);

   pwm_state_t    state;
   logic          pending;
   logic [DW-1:0] sh_period;
   logic [DW-1:0] sh_duty;
   logic          sh_ramp;
   logic [DW-1:0] tgt;
   logic          ramp_en;

   logic [DW-1:0] p_cyc;
   logic          boundary;
   logic          xfer;
   logic          cfg_ok;
   logic          apply;
   logic [DW-1:0] per_n;
   logic [DW-1:0] tgt_n;
   logic          ramp_n;
   logic [DW-1:0] base;
   logic [DW-1:0] goal;
   logic [DW-1:0] duty_n;

   function automatic logic [DW-1:0] toward(
      input logic [DW-1:0] d,
      input logic [DW-1:0] t
   );
      if (d < t) return (t - d > STEP) ? d + STEP : t;
      return (d - t > STEP) ? d - STEP : t;
   endfunction

   assign p_cyc = DW'(us_to_cycles(64'(pwm_period_us), CLK_PERIOD, DW));

   pwm_frame_timer #(
      .DATA_WIDTH(DW)
   ) u_timer (
      .clk          (clk),
      .rst          (rst),
      .period_cycles(p_cyc),
      .boundary     (boundary),
      .frame_start  (frame_start)
   );

   assign cfg_ready = !pending && rst;
   assign xfer      = cfg_valid && cfg_ready;
   assign cfg_ok    = cfg_valid_chk(64'(cfg_period_us), 64'(cfg_duty_us), DW);
   assign busy      = pending || (state == RAMP) || (state == STOP);

   always_comb begin
      apply  = pending && boundary && ((state != IDLE) || enable);
      per_n  = pwm_period_us;
      tgt_n  = tgt;
      ramp_n = ramp_en;
      base   = pwm_duty_us;
      if (apply) begin
         per_n  = sh_period;
         tgt_n  = sh_duty;
         ramp_n = sh_ramp;
         if (pwm_duty_us > sh_period) base = sh_period;
      end
      // Disabling forces the goal to zero; the stored target survives re-enable.
      goal   = enable ? tgt_n : '0;
      duty_n = base;
      if (boundary && ((state != IDLE) || apply)) begin
         duty_n = ramp_n ? toward(base, goal) : goal;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         pending       <= 1'b0;
         sh_period     <= '0;
         sh_duty       <= '0;
         sh_ramp       <= 1'b0;
         tgt           <= '0;
         ramp_en       <= 1'b0;
         pwm_period_us <= '0;
         pwm_duty_us   <= '0;
         cfg_err       <= 1'b0;
      end else begin
         pwm_period_us <= per_n;
         pwm_duty_us   <= duty_n;
         tgt           <= tgt_n;
         ramp_en       <= ramp_n;
         cfg_err       <= xfer && !cfg_ok;
         if (apply) begin
            pending <= 1'b0;
         end else if (xfer && cfg_ok) begin
            pending   <= 1'b1;
            sh_period <= cfg_period_us;
            sh_duty   <= cfg_duty_us;
            sh_ramp   <= cfg_ramp_en;
         end
         unique case (state)
            IDLE: begin
               if (apply) state <= (duty_n == tgt_n) ? RUN : RAMP;
            end
            RUN, RAMP, STOP: begin
               if (!enable) state <= (duty_n == '0) ? IDLE : STOP;
               else state <= (duty_n == tgt_n) ? RUN : RAMP;
            end
         endcase
      end
   end

endmodule
